// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: produces an oversample tick whose average
// period is div_int + div_frac/2^FRAC_W clocks, and a bit tick on every
// OVS-th oversample tick. New divisors are staged in a shadow register and
// only take effect on a period boundary, so no period is ever cut short.
module baud_gen_frac #(
    parameter int DIV_W    = 16,
    parameter int FRAC_W   = 4,
    parameter int OVS      = 16,
    parameter int DEF_INT  = 208,
    parameter int DEF_FRAC = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              sync,
    output logic              tick,
    output logic              bit_tick,
    output logic              cfg_pending,
    output logic              cfg_err
);

    localparam int OVS_W = (OVS > 1) ? $clog2(OVS) : 1;
    localparam int CNT_W = DIV_W + 1;
    localparam logic [OVS_W-1:0]  OVS_LAST   = OVS_W'(OVS - 1);
    localparam logic [DIV_W-1:0]  DEF_INT_V  = DIV_W'(DEF_INT);
    localparam logic [FRAC_W-1:0] DEF_FRAC_V = FRAC_W'(DEF_FRAC);

    logic [DIV_W-1:0]  act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              long_q, long_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OVS_W-1:0]  ovs_q, ovs_d;
    logic [DIV_W-1:0]  sh_int_q, sh_int_d;
    logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;

    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  period_m1;
    logic [FRAC_W:0]   acc_sum;
    logic              load_ok;
    logic              apply;

    // Period is one clock longer whenever the fractional accumulator carried.
    // act_int is never zero, so period_m1 cannot underflow.
    assign period    = {1'b0, act_int_q} + CNT_W'(long_q);
    assign period_m1 = period - CNT_W'(1);
    assign acc_sum   = {1'b0, acc_q} + {1'b0, act_frac_q};

    assign tick        = reset_n & en & ~sync & (cnt_q == period_m1);
    assign bit_tick    = tick & (ovs_q == OVS_LAST);
    assign cfg_pending = pend_q;
    assign cfg_err     = err_q;

    // A zero integer divisor would never produce a tick, so it is refused.
    assign load_ok = load & (div_int != '0);
    // Staged config lands on a period boundary, or immediately while idle;
    // sync only realigns phase and never commits a pending config.
    assign apply   = pend_q & ~sync & (~en | tick);

    // Next-state for counters, accumulator, active and shadow configuration.
    always_comb begin
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        acc_d      = acc_q;
        long_d     = long_q;
        cnt_d      = cnt_q;
        ovs_d      = ovs_q;
        sh_int_d   = sh_int_q;
        sh_frac_d  = sh_frac_q;
        pend_d     = pend_q;
        err_d      = load & (div_int == '0);

        if (sync) begin
            cnt_d = '0;
            ovs_d = '0;
        end else if (!en) begin
            if (pend_q) begin
                cnt_d = '0;
            end
        end else if (tick) begin
            cnt_d  = '0;
            ovs_d  = (ovs_q == OVS_LAST) ? '0 : ovs_q + OVS_W'(1);
            acc_d  = acc_sum[FRAC_W-1:0];
            long_d = acc_sum[FRAC_W];
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Applying a new divisor restarts the fractional sequence from zero.
        if (apply) begin
            act_int_d  = sh_int_q;
            act_frac_d = sh_frac_q;
            acc_d      = '0;
            long_d     = 1'b0;
        end

        // A load in the same cycle as an apply wins: it re-arms pending.
        if (load_ok) begin
            sh_int_d  = div_int;
            sh_frac_d = div_frac;
            pend_d    = 1'b1;
        end else if (apply) begin
            pend_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset to default divisor.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_int_q  <= DEF_INT_V;
            act_frac_q <= DEF_FRAC_V;
            acc_q      <= '0;
            long_q     <= 1'b0;
            cnt_q      <= '0;
            ovs_q      <= '0;
            sh_int_q   <= DEF_INT_V;
            sh_frac_q  <= DEF_FRAC_V;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            acc_q      <= acc_d;
            long_q     <= long_d;
            cnt_q      <= cnt_d;
            ovs_q      <= ovs_d;
            sh_int_q   <= sh_int_d;
            sh_frac_q  <= sh_frac_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: expected tick gaps and bit_tick flags
// are queued as stimulus is applied and compared as the ticks arrive.
module tb_baud_gen_frac;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OVS    = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              en = 1'b0;
    logic              load = 1'b0;
    logic              sync = 1'b0;
    logic [DIV_W-1:0]  div_int = '0;
    logic [FRAC_W-1:0] div_frac = '0;
    logic              tick, bit_tick, cfg_pending, cfg_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   gap;
        logic bt;
    } exp_t;

    exp_t sb[$];
    int   ovs_m = 0;

    always #5 clk = ~clk;

    baud_gen_frac #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS), .DEF_INT(208), .DEF_FRAC(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .load(load),
        .div_int(div_int), .div_frac(div_frac), .sync(sync),
        .tick(tick), .bit_tick(bit_tick),
        .cfg_pending(cfg_pending), .cfg_err(cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Queue one expected tick; bit flag follows the oversample phase model.
    task automatic push(input int gap);
        exp_t e;
        e.gap = gap;
        e.bt  = (ovs_m == OVS - 1);
        sb.push_back(e);
        ovs_m = (ovs_m + 1) % OVS;
    endtask

    // Wait (bounded) for the next tick, counting negedges from 'start'.
    task automatic run_tick(input string tag, input int start, output int gap);
        exp_t e;
        int   n;
        logic seen;
        n    = start;
        seen = 1'b0;
        gap  = 0;
        if (sb.size() == 0) begin
            chk({tag, " queue"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            n++;
            if (tick) begin
                seen = 1'b1;
                break;
            end
        end
        gap = n;
        chk({tag, " seen"}, seen, 1);
        chk({tag, " gap"}, n, e.gap);
        chk({tag, " bit_tick"}, bit_tick, e.bt);
    endtask

    task automatic config_idle(input int i, input int f);
        @(negedge clk);
        en = 1'b0; load = 1'b1; div_int = DIV_W'(i); div_frac = FRAC_W'(f);
        @(negedge clk);
        load = 1'b0;
        chk("pending latency", cfg_pending, 1);
        @(negedge clk);
        chk("pending cleared idle", cfg_pending, 0);
        en = 1'b1;
    endtask

    initial begin
        int g;
        int sum;
        int acc_m;
        int long_m;
        int tmp;
        int nt;

        // Reset defaults
        @(negedge clk);
        chk("rst tick", tick, 0);
        chk("rst bit_tick", bit_tick, 0);
        chk("rst cfg_pending", cfg_pending, 0);
        chk("rst cfg_err", cfg_err, 0);
        @(negedge clk);
        reset_n = 1'b1; en = 1'b1;
        push(207);
        for (int k = 0; k < 15; k++) push(208);
        for (int k = 0; k < 16; k++) run_tick("def", 0, g);
        chk("def cfg_pending", cfg_pending, 0);
        chk("def cfg_err", cfg_err, 0);

        // Fractional divisor 5 + 8/16
        config_idle(5, 8);
        acc_m = 0; long_m = 0;
        for (int k = 0; k < 33; k++) begin
            push(5 + long_m - ((k == 0) ? 1 : 0));
            tmp    = acc_m + 8;
            long_m = (tmp >= 16) ? 1 : 0;
            acc_m  = tmp % 16;
        end
        sum = 0;
        for (int k = 0; k < 33; k++) begin
            run_tick("frac", 0, g);
            if (k > 0) sum += g;
        end
        chk("frac 32-tick span", sum, 176);

        // Reload mid-period does not truncate the running period
        config_idle(10, 0);
        push(9);
        run_tick("div10", 0, g);
        repeat (4) @(negedge clk);
        load = 1'b1; div_int = 16'd4; div_frac = 4'd0;
        @(negedge clk);
        load = 1'b0;
        chk("reload pending set", cfg_pending, 1);
        push(10);
        run_tick("reload end", 5, g);
        chk("reload pending at tick", cfg_pending, 1);
        for (int k = 0; k < 3; k++) push(4);
        run_tick("div4 first", 0, g);
        chk("reload pending cleared", cfg_pending, 0);
        run_tick("div4", 0, g);
        run_tick("div4", 0, g);

        // Zero divisor rejected
        @(negedge clk);
        load = 1'b1; div_int = '0; div_frac = 4'd3;
        @(negedge clk);
        load = 1'b0;
        chk("zero cfg_err pulse", cfg_err, 1);
        chk("zero cfg_pending", cfg_pending, 0);
        @(negedge clk);
        chk("zero cfg_err clear", cfg_err, 0);
        push(4);
        run_tick("zero spacing", 3, g);
        push(4);
        run_tick("zero spacing", 0, g);

        // Phase sync
        config_idle(5, 0);
        push(4);
        run_tick("div5", 0, g);
        while (ovs_m != 7) begin
            push(5);
            run_tick("div5 align", 0, g);
        end
        repeat (3) @(negedge clk);
        sync = 1'b1;
        #1;
        chk("sync no tick", tick, 0);
        @(negedge clk);
        sync = 1'b0;
        ovs_m = 0;
        push(5);
        run_tick("after sync", 1, g);
        for (int k = 0; k < 15; k++) begin
            push(5);
            run_tick("post sync", 0, g);
        end
        repeat (5) @(negedge clk);
        chk("tick due", tick, 1);
        sync = 1'b1;
        #1;
        chk("sync over tick", tick, 0);
        chk("sync over bit_tick", bit_tick, 0);
        @(negedge clk);
        sync = 1'b0;
        ovs_m = 0;
        push(5);
        run_tick("after sync2", 1, g);

        // Enable gap mid-period
        config_idle(8, 0);
        push(7);
        run_tick("div8", 0, g);
        repeat (4) @(negedge clk);
        en = 1'b0;
        nt = 0;
        repeat (20) begin
            @(negedge clk);
            if (tick) nt++;
        end
        chk("en gap ticks", nt, 0);
        en = 1'b1;
        push(4);
        run_tick("en resume", 0, g);

        // Asynchronous reset mid-period with a pending config
        @(negedge clk);
        load = 1'b1; div_int = 16'd3; div_frac = 4'd0;
        @(negedge clk);
        load = 1'b0;
        chk("pre-reset pending", cfg_pending, 1);
        reset_n = 1'b0;
        #1;
        chk("async rst cfg_pending", cfg_pending, 0);
        chk("async rst tick", tick, 0);
        chk("async rst bit_tick", bit_tick, 0);
        chk("async rst cfg_err", cfg_err, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        ovs_m = 0;
        push(207);
        run_tick("post-reset default", 0, g);
        chk("post-reset pending", cfg_pending, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
Runtime-programmable fractional baud-rate generator for the UART datapath. It produces an oversample tick (OVS per bit) and a bit tick. Its average oversample period is div_int + div_frac/2^FRAC_W clock cycles. It adds a glitch-free reload handshake, an enable, and a receiver phase-sync input.

Parameters:
DIV_W, 16, width of integer divisor
FRAC_W, 4, width of fractional divisor; resolution 1/2^FRAC_W cycle
OVS, 16, oversample ticks per bit tick (>=2)
DEF_INT, 208, integer divisor loaded at reset (>=1)
DEF_FRAC, 0, fractional divisor loaded at reset

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
en  in  1  count enable; counters hold when low
load  in  1  single-cycle strobe, capture div_int/div_frac into shadow registers
div_int  in  DIV_W  requested integer divisor
div_frac  in  FRAC_W  requested fractional divisor
sync  in  1  restart oversample and bit phase (e.g. on RX start-bit edge)
tick  out  1  oversample tick, one cycle wide
bit_tick  out  1  bit tick, one cycle wide, coincident with every OVS-th tick
cfg_pending  out  1  shadow config captured, not yet active
cfg_err  out  1  one-cycle pulse: load rejected

Behaviour:
- State: act_int, act_frac, acc[FRAC_W], long (1b), cnt[DIV_W+1], ovs_cnt[clog2(OVS)], shadow int/frac, pending.
- Reset (reset_n=0, async): act_int=DEF_INT, act_frac=DEF_FRAC, acc=0, long=0, cnt=0, ovs_cnt=0, pending=0. All outputs are 0.
- Current period P = act_int + long, computed at full width with no overflow; DIV_W+1 bits.
- tick is combinational from registers: tick = en & ~sync & (cnt == P-1).
- bit_tick = tick & (ovs_cnt == OVS-1).
- When en=1, sync=0 and tick=0: cnt <= cnt+1.
- When tick=1:
  - cnt <= 0.
  - {c, acc} <= acc + act_frac; long <= c.
  - ovs_cnt <= (ovs_cnt == OVS-1) ? 0 : ovs_cnt+1.
- Config apply at tick:
  - If pending=1 at a tick, act_int/act_frac <= shadow, acc <= 0, long <= 0, pending <= 0.
  - This overrides the accumulator update above. The new divisor governs the next period.
  - The period in progress is never truncated or stretched.
- Load handling:
  - When load=1 and div_int != 0: shadow <= inputs, pending <= 1.
  - A second load while pending overwrites the shadow; last load wins.
  - When load=1 and div_int == 0: shadow is unchanged, cfg_err=1 for the next cycle only (registered).
- en=0:
  - cnt, ovs_cnt, acc and long hold; tick=bit_tick=0.
  - If pending=1, config applies on the next edge (acc <= 0, long <= 0), cnt <= 0, pending <= 0.
- sync=1 (en don't-care): cnt <= 0, ovs_cnt <= 0, acc and long hold, no tick that cycle.
  - The next tick occurs P cycles after sync deasserts with en=1.
  - A pending config is not applied by sync.
- Simultaneous events:
  - Reset dominates everything.
  - sync dominates tick.
  - load and tick in the same cycle: the apply uses the old shadow/pending value and the new load captures. pending ends 1 if the new load is valid.
- div_int=1, frac=0: tick every cycle; bit_tick every OVS cycles.
- cfg_pending = pending (registered).
- Latency: load strobe to cfg_pending high is 1 cycle.
- The long-run average tick period is exact: (2^FRAC_W*act_int + act_frac)/2^FRAC_W.

Test Plan:
- Reset defaults, en=1 -> tick every 208 cycles, first at cycle 207 after reset release; bit_tick every 3328 cycles; cfg_pending=0, cfg_err=0.
- load div_int=5, div_frac=8 with en=0 -> active next cycle; with en=1, tick periods 5,5,6,5,6,...; 32 ticks span exactly 176 cycles.
- Running at div 10/0, load 4/0 at cnt=3 -> current period ends at 10 cycles, then 4-cycle periods; cfg_pending high from load+1 until that tick.
- load div_int=0 -> cfg_err single pulse next cycle, tick spacing unchanged, cfg_pending stays 0.
- Div 5/0, OVS=16, sync pulse at ovs_cnt=7, cnt=2 -> no tick in sync cycle; next tick 5 cycles later; bit_tick on the 16th tick after sync.
- en low for 20 cycles mid-period (cnt=3 of 8) -> no ticks during the gap; first tick 4 enabled cycles after en returns; assert reset_n=0 mid-period -> outputs 0 immediately, defaults restored.
